// File: rtl/mod_updown_counter_if.sv
// Control/status bundle for mod_updown_counter.
// master: the sequencing logic that drives the counter; slave: the counter itself.
interface mod_updown_counter_if #(
  parameter int unsigned WIDTH = 2
);
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  count, tc, wrap, load_err
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output count, tc, wrap, load_err
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo-N up/down counter with prescaler, synchronous clear/load and wrap/saturate mode.
// The bus interface must be instantiated with the same WIDTH as this module.
module mod_updown_counter #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned MODULUS  = 3,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned SATURATE = 0
) (
  input logic                 clk,
  input logic                 rst,
  mod_updown_counter_if.slave bus
);

  localparam int unsigned      PsW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [WIDTH-1:0] CntMax = WIDTH'(MODULUS - 1);
  localparam logic [PsW-1:0]   PsMax  = PsW'(PRESCALE - 1);
  localparam logic [WIDTH:0]   ModExt = (WIDTH + 1)'(MODULUS);
  localparam bit               DoWrap = (SATURATE == 0);

  if (MODULUS < 2 || 64'(MODULUS) > (64'd1 << WIDTH) || PRESCALE < 1) begin : g_param_err
    $error("mod_updown_counter: illegal MODULUS/WIDTH/PRESCALE combination");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [PsW-1:0]   ps_q, ps_d;
  logic             wrap_q, wrap_d;
  logic             load_err_q, load_err_d;
  logic             ps_last, step, at_end, load_oor, tc_int;

  // Step qualification, range-end detection and out-of-range load detection.
  always_comb begin
    ps_last  = (ps_q == PsMax);
    step     = bus.en & ps_last;
    at_end   = bus.up_dn ? (count_q == CntMax) : (count_q == '0);
    load_oor = ({1'b0, bus.load_val} >= ModExt);
    // clr/load override stepping, so they also hide the terminal count.
    tc_int   = step & at_end & ~bus.clr & ~bus.load;
  end

  // Next-state: clr > load > stepping.
  always_comb begin
    count_d    = count_q;
    ps_d       = ps_q;
    wrap_d     = tc_int & DoWrap;
    load_err_d = 1'b0;
    if (bus.clr) begin
      count_d = '0;
      ps_d    = '0;
    end else if (bus.load) begin
      count_d    = load_oor ? CntMax : bus.load_val;
      ps_d       = '0;
      load_err_d = load_oor;
    end else if (bus.en) begin
      ps_d = ps_last ? '0 : ps_q + 1'b1;
      if (step) begin
        if (at_end) begin
          if (DoWrap) begin
            count_d = bus.up_dn ? '0 : CntMax;
          end
        end else begin
          count_d = bus.up_dn ? count_q + 1'b1 : count_q - 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      ps_q       <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      ps_q       <= ps_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.tc       = tc_int;
  assign bus.wrap     = wrap_q;
  assign bus.load_err = load_err_q;

endmodule
